reg_share_arbiter: RTL and testbench

- Shares one storage register (mkReg semantics: `init` reset value, enabled write, registered read) among `nreq` requesters.
- Arbitration is round-robin. A requester may lock the register for multi-cycle exclusive ownership; a hold-timeout bounds how long a lock can last.
- Sits between several pipeline stages/rules and a shared state register, e.g. a shared CSR or counter.

---
 rtl/reg_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: one shared storage register written by up to 16 requesters.
// Writers are granted round-robin. A granted writer may lock the register for
// exclusive multi-cycle ownership, and an optional hold timeout bounds the lock.
// OUT_READ behaves like a plain enabled register: a grant in one cycle shows up
// on OUT_READ the next cycle.
// Legal configurations: 1 <= nreq <= 16. A width of 0 is built as a 1-bit register.

module reg_share_arbiter #(
  parameter int width = 8,
  parameter logic [((width > 0) ? width : 1)-1:0] init = '0,
  parameter int nreq = 4,
  parameter int max_hold = 15
) (
  input  logic                                             CLK,
  input  logic                                             RST_N,
  input  logic [nreq-1:0]                                  IN_EN_WRITE,
  input  logic [nreq*((width > 0) ? width : 1)-1:0]        IN_WRITE,
  input  logic [nreq-1:0]                                  IN_LOCK,
  output logic [((width > 0) ? width : 1)-1:0]             OUT_READ,
  output logic [nreq-1:0]                                  OUT_GRANT,
  output logic                                             OUT_LOCKED,
  output logic [((nreq > 1) ? $clog2(nreq) : 1)-1:0]       OUT_OWNER,
  output logic                                             OUT_TIMEOUT
);

  // Effective data width, requester-index width and hold-counter width.
  localparam int W  = (width > 0) ? width : 1;
  localparam int PW = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int HW = (max_hold > 0) ? $clog2(max_hold + 1) : 1;

  // Counter value seen in the last cycle a lock may last. It is unused when max_hold is 0.
  localparam logic [HW-1:0] HOLD_LAST = (max_hold > 0) ? HW'(max_hold - 1) : '0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [HW-1:0]   hold_q;
  logic            locked_q;
  logic            timeout_q;
  // The register starts at init even before the first reset edge.
  logic [W-1:0]    read_q = init;

  logic [nreq-1:0] grant;
  logic            grant_any;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_adv;
  logic [W-1:0]    win_data;
  logic            found;
  int              idx;
  int              nxt;
  logic [PW-1:0]   idx_v;

  // Grant selection: a rotating priority scan in IDLE, or owner-only while locked.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value held and no latch is inferred.
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_v   = '0;
    if (state_q == ST_LOCKED) begin
      // Other requesters are ignored, not queued. The owner is granted only when it asks to write.
      grant[owner_q] = IN_EN_WRITE[owner_q];
      win_idx        = owner_q;
    end else begin
      for (int k = 0; k < nreq; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= nreq) idx = idx - nreq;
        idx_v = PW'(idx);
        if (!found && IN_EN_WRITE[idx_v]) begin
          found        = 1'b1;
          win_idx      = idx_v;
          grant[idx_v] = 1'b1;
        end
      end
    end
    // No grant escapes while reset is held, whatever the requests are.
    if (!RST_N) grant = '0;
  end

  // Next pointer is (winner + 1) mod nreq; while locked the winner is the owner.
  always_comb begin
    nxt = int'(win_idx) + 1;
    if (nxt >= nreq) nxt = 0;
    ptr_adv  = PW'(nxt);
    win_data = IN_WRITE[int'(win_idx)*W +: W];
  end

  assign grant_any = |grant;

  // Arbitration FSM, shared register, pointer and hold counter, all with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // NOTE: state updates use non-blocking assignments, so every register samples pre-edge values.
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      read_q    <= init;
    end else begin
      timeout_q <= 1'b0;
      if (grant_any) read_q <= win_data;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) ptr_q <= ptr_adv;
          // Only the winner's lock request counts, and a lock needs a granted write.
          if (grant_any && IN_LOCK[win_idx]) begin
            state_q  <= ST_LOCKED;
            owner_q  <= win_idx;
            hold_q   <= '0;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (grant_any) ptr_q <= ptr_adv;
          if (!IN_LOCK[owner_q]) begin
            // Voluntary release. This takes priority over a timeout in the same cycle.
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            hold_q   <= '0;
            locked_q <= 1'b0;
          end else if ((max_hold > 0) && (hold_q == HOLD_LAST)) begin
            // Forced release. The pointer moves past the owner so it gets lowest priority.
            state_q   <= ST_IDLE;
            ptr_q     <= ptr_adv;
            owner_q   <= '0;
            hold_q    <= '0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else if (max_hold > 0) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign OUT_READ    = read_q;
  assign OUT_GRANT   = grant;
  assign OUT_LOCKED  = locked_q;
  assign OUT_OWNER   = owner_q;
  assign OUT_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with hand-computed expected values.
// u_main: width=8, init=8'h5A, nreq=4, max_hold=4.
// u_edge: width=0 (built as 1 bit), init=1, nreq=1, max_hold=2.

module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  en;
  logic [3:0]  lk;
  logic [31:0] wr;
  logic [7:0]  rd;
  logic [3:0]  gnt;
  logic        locked;
  logic [1:0]  owner;
  logic        tmo;

  logic        e_en;
  logic        e_wr;
  logic        e_lk;
  logic        e_rd;
  logic        e_gnt;
  logic        e_locked;
  logic        e_owner;
  logic        e_tmo;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(
    .width(8), .init(8'h5A), .nreq(4), .max_hold(4)
  ) u_main (
    .CLK(clk), .RST_N(rst_n),
    .IN_EN_WRITE(en), .IN_WRITE(wr), .IN_LOCK(lk),
    .OUT_READ(rd), .OUT_GRANT(gnt), .OUT_LOCKED(locked),
    .OUT_OWNER(owner), .OUT_TIMEOUT(tmo)
  );

  reg_share_arbiter #(
    .width(0), .init(1'b1), .nreq(1), .max_hold(2)
  ) u_edge (
    .CLK(clk), .RST_N(rst_n),
    .IN_EN_WRITE(e_en), .IN_WRITE(e_wr), .IN_LOCK(e_lk),
    .OUT_READ(e_rd), .OUT_GRANT(e_gnt), .OUT_LOCKED(e_locked),
    .OUT_OWNER(e_owner), .OUT_TIMEOUT(e_tmo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every main requester asserting a write.
    rst_n = 1'b0;
    en = 4'hF; lk = 4'h0; wr = 32'h0102_0304;
    e_en = 1'b1; e_wr = 1'b0; e_lk = 1'b0;
    #1;
    check("init_read", 32'(rd), 32'h5A);
    check("edge_init_read", 32'(e_rd), 32'h1);
    check("rst_grant_zero", 32'(gnt), 32'h0);
    check("edge_rst_grant_zero", 32'(e_gnt), 32'h0);
    tick();
    check("rst_read", 32'(rd), 32'h5A);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_timeout", 32'(tmo), 32'h0);
    check("edge_rst_read", 32'(e_rd), 32'h1);

    // Round-robin with all four writing: grants 0,1,2,3,0, and the read value lags by one cycle.
    rst_n = 1'b1;
    e_en  = 1'b0;
    wr    = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", 32'(gnt), 32'(4'b0001 << (i % 4)));
      tick();
      check("rr_read", 32'(rd), 32'(8'h10 + (i % 4)));
    end

    // Single request from req1 moves the pointer to 2.
    en = 4'b0010; wr = {8'h00, 8'h00, 8'h21, 8'h00};
    #1;
    check("solo_grant", 32'(gnt), 32'h2);
    tick();
    check("solo_read", 32'(rd), 32'h21);

    // Lock: req2 holds EN+LOCK for 3 cycles while req0 and req1 also request.
    en = 4'b0111; lk = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) lk = 4'b0000;
      wr = {8'h00, 8'(8'hC0 + c), 8'hA1, 8'hA0};
      #1;
      check("lock_grant", 32'(gnt), 32'h4);
      tick();
      check("lock_read", 32'(rd), 32'(8'hC0 + c));
      check("lock_state", 32'(locked), (c < 3) ? 32'h1 : 32'h0);
      check("lock_owner", 32'(owner), (c < 3) ? 32'h2 : 32'h0);
    end
    check("release_no_tmo", 32'(tmo), 32'h0);

    // After the release the pointer is 3, so req3 wins over req0 and req1.
    en = 4'b1011; wr = {8'h33, 8'h00, 8'hB1, 8'hB0};
    #1;
    check("post_release_grant", 32'(gnt), 32'h8);
    tick();
    check("post_release_read", 32'(rd), 32'h33);

    // LOCK without EN grants nothing and acquires nothing.
    en = 4'b0000; lk = 4'b1111;
    #1;
    check("lock_only_grant", 32'(gnt), 32'h0);
    tick();
    check("lock_only_state", 32'(locked), 32'h0);
    check("lock_only_read", 32'(rd), 32'h33);

    // Pointer is 0: req0 wins over req1.
    en = 4'b0011; lk = 4'b0000; wr = {8'h00, 8'h00, 8'h51, 8'h50};
    #1;
    check("ptr0_grant", 32'(gnt), 32'h1);
    tick();
    check("ptr0_read", 32'(rd), 32'h50);

    // Timeout: req1 acquires, then holds 4 locked cycles and is forced out.
    en = 4'hF; lk = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      wr = {8'hE3, 8'hE2, 8'(8'h40 + c), 8'hE0};
      #1;
      check("hold_grant", 32'(gnt), 32'h2);
      tick();
      check("hold_read", 32'(rd), 32'(8'h40 + c));
      check("hold_locked", 32'(locked), (c < 4) ? 32'h1 : 32'h0);
      check("hold_owner", 32'(owner), (c < 4) ? 32'h1 : 32'h0);
      check("hold_timeout", 32'(tmo), (c < 4) ? 32'h0 : 32'h1);
    end

    // The forced-out owner has lowest priority, and the timeout pulse lasts one cycle.
    #1;
    check("post_tmo_grant", 32'(gnt), 32'h4);
    tick();
    check("tmo_pulse_end", 32'(tmo), 32'h0);
    check("post_tmo_read", 32'(rd), 32'hE2);
    check("post_tmo_unlocked", 32'(locked), 32'h0);

    // req3 takes the lock, then reset is applied mid-lock.
    lk = 4'b1000;
    #1;
    check("req3_grant", 32'(gnt), 32'h8);
    tick();
    check("req3_locked", 32'(locked), 32'h1);
    check("req3_owner", 32'(owner), 32'h3);
    #1;
    check("req3_excl_grant", 32'(gnt), 32'h8);
    rst_n = 1'b0;
    #1;
    check("midlock_rst_grant", 32'(gnt), 32'h0);
    tick();
    check("midlock_locked", 32'(locked), 32'h0);
    check("midlock_timeout", 32'(tmo), 32'h0);
    check("midlock_read", 32'(rd), 32'h5A);
    check("midlock_owner", 32'(owner), 32'h0);
    rst_n = 1'b1; en = 4'b1110; lk = 4'b0000;
    #1;
    check("post_rst_grant", 32'(gnt), 32'h2);
    tick();
    en = 4'b0000;

    // Edge configuration: one requester with 1-bit data.
    e_en = 1'b1; e_wr = 1'b0; e_lk = 1'b0;
    #1;
    check("edge_grant", 32'(e_gnt), 32'h1);
    tick();
    check("edge_read0", 32'(e_rd), 32'h0);
    e_wr = 1'b1;
    tick();
    check("edge_read1", 32'(e_rd), 32'h1);
    e_en = 1'b0; e_wr = 1'b0;
    #1;
    check("edge_no_grant", 32'(e_gnt), 32'h0);
    tick();
    check("edge_no_write", 32'(e_rd), 32'h1);

    // Edge lock: acquire, one locked cycle, then timeout (max_hold=2), then re-acquire.
    e_en = 1'b1; e_lk = 1'b1;
    for (int c = 0; c < 4; c++) begin
      e_wr = c[0];
      #1;
      check("edge_lock_grant", 32'(e_gnt), 32'h1);
      tick();
      check("edge_lock_read", 32'(e_rd), 32'(c[0]));
      check("edge_lock_state", 32'(e_locked), (c == 2) ? 32'h0 : 32'h1);
      check("edge_lock_tmo", 32'(e_tmo), (c == 2) ? 32'h1 : 32'h0);
    end
    check("edge_owner", 32'(e_owner), 32'h0);
    e_lk = 1'b0;
    tick();
    check("edge_release", 32'(e_locked), 32'h0);
    check("edge_release_tmo", 32'(e_tmo), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
